// File: rtl/apb_mem_completer.sv
// rtl/apb_mem_completer.sv - APB completer bridging to a single-port synchronous memory
// Four-state FSM: one ISSUE cycle per transfer, optional wait states, writes above PROT_BASE rejected.
module apb_mem_completer #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 21,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] PROT_BASE   = 8'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [ADDR_W-1:0] addr,
  output logic              ce,
  output logic              wren,
  output logic              rden,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state, state_n;
  logic [3:0]        wcnt, wcnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q, prot_q;
  logic              setup, prot_in;
  logic              ce_n, wren_n, rden_n, pready_n, pslverr_n;

  assign setup   = psel && !penable;
  assign prot_in = pwrite && (paddr >= PROT_BASE);

  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    ce_n      = 1'b0;
    wren_n    = 1'b0;
    rden_n    = 1'b0;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_n = ISSUE;
          ce_n    = !prot_in;
          wren_n  = pwrite && !prot_in;
          rden_n  = !pwrite;
        end
      end
      ISSUE: begin
        if (!psel) begin
          state_n = IDLE;
        end else if (WAIT_STATES > 0) begin
          state_n = WAIT;
          wcnt_n  = WAIT_LOAD;
        end else begin
          state_n = DONE;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_n = IDLE;
          wcnt_n  = 4'd0;
        end else if (wcnt == 4'd0) begin
          state_n = DONE;
        end else begin
          wcnt_n  = wcnt - 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        wcnt_n  = 4'd0;
      end
    endcase
    // Completion flags are registered alongside the state they belong to.
    if (state_n == DONE) begin
      pready_n  = 1'b1;
      pslverr_n = prot_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      prot_q  <= 1'b0;
      ce      <= 1'b0;
      wren    <= 1'b0;
      rden    <= 1'b0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      ce      <= ce_n;
      wren    <= wren_n;
      rden    <= rden_n;
      pready  <= pready_n;
      pslverr <= pslverr_n;
      if (state == IDLE && setup) begin
        addr_q  <= paddr;
        wdata_q <= pwdata;
        write_q <= pwrite;
        prot_q  <= prot_in;
      end
    end
  end

  // Memory read data is forwarded combinationally so the registered rd_data is seen in DONE.
  assign prdata  = (state == DONE && !write_q) ? rd_data : '0;
  assign addr    = addr_q;
  assign wr_data = wdata_q;

endmodule

// File: tb/tb_apb_mem_completer.sv
// tb/tb_apb_mem_completer.sv - scoreboard bench for apb_mem_completer with zero and three wait states
module tb_apb_mem_completer;

  typedef struct {
    bit          wr;
    bit          prot;
    bit          abort;
    logic [7:0]  a;
    logic [20:0] wd;
    logic [20:0] rd;
    longint      t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;

  logic        psel[2], penable[2], pwrite[2];
  logic [7:0]  paddr[2];
  logic [20:0] pwdata[2];
  logic [20:0] prdata[2];
  logic        pready[2], pslverr[2];
  logic [7:0]  addr[2];
  logic        ce[2], wren[2], rden[2];
  logic [20:0] wr_data[2], rd_data[2];

  logic [20:0] mem[2][256];
  logic [20:0] ref_mem[2][256];
  exp_t        sb[2][$];
  int          nce[2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_mem_completer #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .addr(addr[0]), .ce(ce[0]), .wren(wren[0]), .rden(rden[0]),
    .wr_data(wr_data[0]), .rd_data(rd_data[0])
  );

  apb_mem_completer #(.WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .addr(addr[1]), .ce(ce[1]), .wren(wren[1]), .rden(rden[1]),
    .wr_data(wr_data[1]), .rd_data(rd_data[1])
  );

  function automatic logic [20:0] init_val(input int d, input int i);
    int v;
    v = (i * 2654435) + (d * 77777) + 21'h15A5A;
    return v[20:0];
  endfunction

  task automatic chk_eq(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory: rd_data registered one edge after ce&rden.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) mem[d][i] <= init_val(d, i);
      end else begin
        if (ce[d] && wren[d]) mem[d][addr[d]] <= wr_data[d];
        if (ce[d] && rden[d]) rd_data[d] <= mem[d][addr[d]];
      end
    end
  end

  // Monitor: pops expectations on strobes and completions.
  always @(negedge clk) begin
    exp_t   e;
    longint lat;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        chk_eq("rden_wren_exclusive", rden[d] && wren[d], 0);
        if (!ce[d]) chk_eq("strobe_without_ce", {wren[d], rden[d]}, 0);
        if (!pready[d]) begin
          chk_eq("prdata_idle_zero", prdata[d], 0);
          chk_eq("pslverr_idle_zero", pslverr[d], 0);
        end
        if (sb[d].size() == 0) begin
          chk_eq("stray_ce", ce[d], 0);
          chk_eq("stray_pready", pready[d], 0);
        end else begin
          e   = sb[d][0];
          lat = (longint'($time) - 5 - e.t0) / 10;
          if (ce[d]) begin
            chk_eq("ce_in_first_cycle", lat, 0);
            chk_eq("strobe_addr", addr[d], e.a);
            chk_eq("strobe_wren", wren[d], e.wr);
            chk_eq("strobe_rden", rden[d], !e.wr);
            if (e.wr) chk_eq("strobe_wr_data", wr_data[d], e.wd);
            nce[d]++;
            if (e.abort) begin
              void'(sb[d].pop_front());
              nce[d] = 0;
            end
          end else if (pready[d]) begin
            void'(sb[d].pop_front());
            chk_eq("latency", lat, (d == 1) ? 4 : 1);
            chk_eq("ce_count", nce[d], e.prot ? 0 : 1);
            chk_eq("pslverr", pslverr[d], e.prot);
            chk_eq("done_addr", addr[d], e.a);
            if (e.wr) chk_eq("done_wr_data", wr_data[d], e.wd);
            else      chk_eq("prdata", prdata[d], e.rd);
            nce[d] = 0;
          end
        end
      end
    end
  end

  // Entry and exit at posedge+1. mode: 0 normal, 1 drop psel in WAIT, 2 reset in WAIT.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [20:0] wd, input int mode);
    exp_t e;
    bit   got;
    e.wr    = wr;
    e.a     = a;
    e.wd    = wd;
    e.prot  = wr && (a >= 8'hF0);
    e.rd    = ref_mem[d][a];
    e.abort = (mode != 0);
    e.t0    = longint'($time) - 1 + 10;
    sb[d].push_back(e);
    if (wr && !e.prot) ref_mem[d][a] = wd;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    if (mode != 0) begin
      @(posedge clk); #1;
      if (mode == 1) begin
        psel[d] = 1'b0; penable[d] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
      end else begin
        #2 rst = 1'b1;
        #1;
        chk_eq("rst_ce", ce[d], 0);
        chk_eq("rst_pready", pready[d], 0);
        chk_eq("rst_addr", addr[d], 0);
        chk_eq("rst_wr_data", wr_data[d], 0);
        psel[d] = 1'b0; penable[d] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      return;
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = pready[d];
    end
    if (!got) chk_eq("pready_timeout", pready[d], 1);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    int          d;
    bit          wr;
    logic [7:0]  a;
    logic [20:0] wd;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 0; penable[i] = 0; pwrite[i] = 0; paddr[i] = '0; pwdata[i] = '0;
      nce[i] = 0;
      for (int j = 0; j < 256; j++) ref_mem[i][j] = init_val(i, j);
    end
    rst = 1'b1;
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_eq("reset_pready", pready[i], 0);
      chk_eq("reset_pslverr", pslverr[i], 0);
      chk_eq("reset_strobes", {ce[i], wren[i], rden[i]}, 0);
      chk_eq("reset_prdata", prdata[i], 0);
      chk_eq("reset_addr", addr[i], 0);
      chk_eq("reset_wr_data", wr_data[i], 0);
    end
    @(posedge clk); #1;
    mem_init = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(0, 1, 8'h10, 21'h1ABCD, 0);
    xfer(0, 0, 8'h10, 21'h0, 0);
    xfer(0, 1, 8'hF3, 21'h00055, 0);
    xfer(0, 0, 8'hF3, 21'h0, 0);
    xfer(0, 1, 8'hEF, 21'h0F0F0, 0);
    xfer(0, 0, 8'hEF, 21'h0, 0);
    xfer(0, 1, 8'hFF, 21'h12345, 0);
    xfer(0, 0, 8'hFF, 21'h0, 0);
    xfer(0, 1, 8'h20, 21'h0BEEF, 0);
    xfer(0, 0, 8'h20, 21'h0, 0);
    @(posedge clk); #1;

    xfer(1, 0, 8'h10, 21'h0, 0);
    xfer(1, 1, 8'h20, 21'h13579, 0);
    xfer(1, 0, 8'h20, 21'h0, 0);
    xfer(1, 0, 8'h20, 21'h0, 2);
    xfer(1, 0, 8'h20, 21'h0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b1; penable[i] = 1'b1; pwrite[i] = 1'b1; paddr[i] = 8'h30; pwdata[i] = 21'h1FFFF;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0;
    end
    xfer(0, 0, 8'h30, 21'h0, 0);
    xfer(1, 0, 8'h30, 21'h0, 0);
    xfer(1, 0, 8'h10, 21'h0, 1);
    xfer(1, 1, 8'h40, 21'h0AAAA, 0);
    xfer(1, 0, 8'h40, 21'h0, 0);

    for (int n = 0; n < 80; n++) begin
      d  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      wd = 21'($urandom);
      case ($urandom_range(0, 3))
        0:       a = 8'h10;
        1:       a = 8'hEE + 8'($urandom_range(0, 3));
        2:       a = 8'hFC + 8'($urandom_range(0, 3));
        default: a = 8'($urandom_range(0, 255));
      endcase
      xfer(d, wr, a, wd, 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    chk_eq("scoreboard_drained0", sb[0].size(), 0);
    chk_eq("scoreboard_drained1", sb[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
